// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: opcodes, load/store func3 codes,
// load/store unit state encoding and error codes.
package rv32_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ACCESS,
        LSU_DONE
    } lsu_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    function automatic logic lsu_illegal(input logic [6:0] opcode, input logic [2:0] func3);
        logic bad;
        bad = 1'b1;
        case (opcode)
            OP_LOAD:  bad = !(func3 == F3_LB || func3 == F3_LH || func3 == F3_LW ||
                              func3 == F3_LBU || func3 == F3_LHU);
            OP_STORE: bad = (func3 > F3_SW);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/ready bus between the load/store unit and the memory slave.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/load_store_unit_lane.sv
// Byte-lane logic: store strobes and replication, load extraction and
// extension, and alignment check for the access size in func3[1:0].
module lsu_lane (
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  func3,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_val,
    output logic        misaligned
);
    logic [31:0] shifted;

    always_comb begin
        wstrb      = '0;
        wdata_rep  = wdata;
        load_val   = mem_rdata;
        misaligned = 1'b0;
        shifted    = mem_rdata >> {addr_lo, 3'b000};
        case (func3[1:0])
            2'b00: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                load_val  = func3[2] ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                load_val   = func3[2] ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            2'b10: begin
                wstrb      = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: one data-memory access per accepted request over a
// req/ready bus, with lane steering, load extension and error reporting.
module load_store_unit
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [6:0]            opcode,
    input  logic [2:0]            func3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [31:0]           rdata,
    load_store_unit_if.master     mem
);
    localparam logic [CNT_W-1:0] WD_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    lsu_state_t       state;
    logic [CNT_W-1:0] wd_cnt;
    logic [2:0]       cap_func3;
    logic [1:0]       cap_addr_lo;
    logic             cap_we;

    logic             mem_req_r;
    logic             mem_we_r;
    logic [31:0]      mem_addr_r;
    logic [3:0]       mem_wstrb_r;
    logic [31:0]      mem_wdata_r;

    logic [1:0]       lane_addr_lo;
    logic [2:0]       lane_func3;
    logic [3:0]       lane_wstrb;
    logic [31:0]      lane_wdata;
    logic [31:0]      lane_load;
    logic             lane_misaligned;
    logic             req_illegal;
    logic             req_store;

    // The lane block decodes the incoming request in IDLE and the captured one afterwards.
    assign lane_addr_lo = (state == LSU_IDLE) ? addr[1:0] : cap_addr_lo;
    assign lane_func3   = (state == LSU_IDLE) ? func3     : cap_func3;
    assign req_illegal  = lsu_illegal(opcode, func3);
    assign req_store    = (opcode == OP_STORE);

    lsu_lane u_lane (
        .addr_lo    (lane_addr_lo),
        .func3      (lane_func3),
        .wdata      (wdata),
        .mem_rdata  (mem.mem_rdata),
        .wstrb      (lane_wstrb),
        .wdata_rep  (lane_wdata),
        .load_val   (lane_load),
        .misaligned (lane_misaligned)
    );

    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wstrb = mem_wstrb_r;
    assign mem.mem_wdata = mem_wdata_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LSU_IDLE;
            wd_cnt      <= '0;
            cap_func3   <= '0;
            cap_addr_lo <= '0;
            cap_we      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            rdata       <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wstrb_r <= '0;
            mem_wdata_r <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    err      <= 1'b0;
                    err_code <= ERR_NONE;
                    if (start) begin
                        cap_func3   <= func3;
                        cap_addr_lo <= addr[1:0];
                        cap_we      <= req_store;
                        busy        <= 1'b1;
                        if (req_illegal || lane_misaligned) begin
                            state    <= LSU_DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            err_code <= req_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                            rdata    <= '0;
                        end else begin
                            state       <= LSU_ACCESS;
                            wd_cnt      <= '0;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= req_store;
                            mem_addr_r  <= {addr[31:2], 2'b00};
                            mem_wstrb_r <= req_store ? lane_wstrb : 4'b0000;
                            mem_wdata_r <= req_store ? lane_wdata : 32'h0;
                        end
                    end
                end
                LSU_ACCESS: begin
                    if (mem.mem_ready || (TIMEOUT_CYCLES != 0 && wd_cnt == WD_LAST)) begin
                        state       <= LSU_DONE;
                        done        <= 1'b1;
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= '0;
                        mem_wstrb_r <= '0;
                        mem_wdata_r <= '0;
                        if (mem.mem_ready) begin
                            err      <= 1'b0;
                            err_code <= ERR_NONE;
                            rdata    <= cap_we ? 32'h0 : lane_load;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_TIMEOUT;
                            rdata    <= '0;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                LSU_DONE: begin
                    state    <= LSU_IDLE;
                    busy     <= 1'b0;
                    err      <= 1'b0;
                    err_code <= ERR_NONE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against an arithmetic reference model.
module tb_load_store_unit;
    localparam int unsigned T = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] rdata;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_rdata = '0;

    load_store_unit_if mif ();

    load_store_unit #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .opcode   (opcode),
        .func3    (func3),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .rdata    (rdata),
        .mem      (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: expected bus fields and result derived from access size arithmetic.
    task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word,
                         input int unsigned delay, input bit noise);
        bit          is_ld, is_st, legal, mis;
        int unsigned size, off, exp_done;
        logic [1:0]  exp_code;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wd, mask, val, shifted;

        is_ld = (op == 7'b0000011);
        is_st = (op == 7'b0100011);
        legal = (is_ld && (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5)) || (is_st && f3 <= 3'd2);
        size  = 1 << f3[1:0];
        off   = a % 4;
        mis   = legal && (a % size != 0);
        if (!legal)          exp_code = 2'b10;
        else if (mis)        exp_code = 2'b01;
        else if (delay <= T) exp_code = 2'b00;
        else                 exp_code = 2'b11;
        if (!legal || mis)   exp_done = 1;
        else if (delay <= T) exp_done = delay + 1;
        else                 exp_done = T + 1;

        exp_strb = '0;
        exp_wd   = '0;
        if (is_st) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) exp_strb[i] = 1'b1;
                exp_wd[8*i +: 8] = 8'((wd >> (8 * (i % size))) & 32'hFF);
            end
        end
        shifted = word >> (8 * off);
        mask    = (size >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
        val     = shifted & mask;
        if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;

        start  = 1'b1;
        opcode = op;
        func3  = f3;
        addr   = a;
        wdata  = wd;
        mif.mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        mif.mem_rdata = $urandom;

        for (int unsigned c = 1; c <= exp_done; c++) begin
            step();
            start         = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            opcode        = noise ? 7'($urandom) : op;
            addr          = noise ? $urandom : a;
            mif.mem_ready = 1'b0;
            mif.mem_rdata = $urandom;
            if (c < exp_done) begin
                check("mem_req", 32'(mif.mem_req), 32'd1);
                check("busy_acc", 32'(busy), 32'd1);
                check("done_early", 32'(done), 32'd0);
                check("mem_addr", mif.mem_addr, {a[31:2], 2'b00});
                check("mem_we", 32'(mif.mem_we), 32'(is_st));
                check("mem_wstrb", 32'(mif.mem_wstrb), 32'(exp_strb));
                check("mem_wdata", mif.mem_wdata, exp_wd);
                if (c == delay) begin
                    mif.mem_ready = 1'b1;
                    mif.mem_rdata = word;
                end
            end else begin
                if (exp_code == 2'b00 && is_ld) exp_rdata = val;
                else                            exp_rdata = '0;
                check("done", 32'(done), 32'd1);
                check("busy_done", 32'(busy), 32'd1);
                check("err", 32'(err), 32'(exp_code != 2'b00));
                check("err_code", 32'(err_code), 32'(exp_code));
                check("rdata", rdata, exp_rdata);
                check("mem_req_off", 32'(mif.mem_req), 32'd0);
                if (noise) mif.mem_ready = 1'($urandom_range(0, 1));
            end
        end
        step();
        start         = 1'b0;
        mif.mem_ready = 1'b0;
        check("done_single", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("rdata_hold", rdata, exp_rdata);
    endtask

    task automatic reset_mid_access();
        start  = 1'b1;
        opcode = 7'b0000011;
        func3  = 3'b010;
        addr   = 32'h400;
        wdata  = '0;
        step();
        start = 1'b0;
        check("rst_pre_req", 32'(mif.mem_req), 32'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        exp_rdata = '0;
        check("rst_req", 32'(mif.mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_no_done", 32'(done), 32'd0);
            check("rst_no_req", 32'(mif.mem_req), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic [31:0] a;
        rst_n = 1'b0;
        start = 1'b0;
        opcode = '0;
        func3 = '0;
        addr = '0;
        wdata = '0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = '0;
        step();
        step();
        check("rst_busy0", 32'(busy), 32'd0);
        check("rst_done0", 32'(done), 32'd0);
        check("rst_err0", 32'(err), 32'd0);
        check("rst_code0", 32'(err_code), 32'd0);
        check("rst_rdata0", rdata, 32'd0);
        check("rst_req0", 32'(mif.mem_req), 32'd0);
        check("rst_we0", 32'(mif.mem_we), 32'd0);
        check("rst_maddr0", mif.mem_addr, 32'd0);
        check("rst_strb0", 32'(mif.mem_wstrb), 32'd0);
        check("rst_mwd0", mif.mem_wdata, 32'd0);
        rst_n = 1'b1;
        step();

        do_op(7'b0100011, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, 1'b0);
        do_op(7'b0000011, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 1, 1'b0);
        check("lb_const", rdata, 32'hFFFFFF80);
        do_op(7'b0000011, 3'b100, 32'h203, 32'h0, 32'h80FF_1234, 2, 1'b0);
        check("lbu_const", rdata, 32'h00000080);
        do_op(7'b0100011, 3'b001, 32'h302, 32'h0000ABCD, 32'h0, 1, 1'b0);
        do_op(7'b0000011, 3'b101, 32'h302, 32'h0, 32'hBEEF_0000, 3, 1'b0);
        check("lhu_const", rdata, 32'h0000BEEF);
        do_op(7'b0000011, 3'b010, 32'h102, 32'h0, 32'h0, 1, 1'b0);
        do_op(7'b0000011, 3'b001, 32'h101, 32'h0, 32'h0, 1, 1'b0);
        do_op(7'b0110011, 3'b000, 32'h100, 32'h0, 32'h0, 1, 1'b0);
        do_op(7'b0000011, 3'b010, 32'h500, 32'h0, 32'h1234_5678, 99, 1'b0);
        do_op(7'b0000011, 3'b010, 32'h500, 32'h0, 32'h1234_5678, T, 1'b0);
        check("late_ready_const", rdata, 32'h1234_5678);
        do_op(7'b0100011, 3'b011, 32'h600, 32'h0, 32'h0, 1, 1'b1);
        do_op(7'b0000011, 3'b110, 32'h600, 32'h0, 32'h0, 1, 1'b1);

        reset_mid_access();

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       op = 7'($urandom);
                1, 2, 3: op = 7'b0100011;
                default: op = 7'b0000011;
            endcase
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : {a[1], 1'b0};
            do_op(op, f3, a, $urandom, $urandom, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
